// File: rtl/bdu_bit_streamer.sv
// Streams a latched query point and a batch of per-lane reference points MSB-first, one
// (bit, axis) beat per cycle, onto the BDU lanes. Optional `stall` input under BDU_STREAM_STALL_EN.
module bdu_bit_streamer #(
  parameter int unsigned NUM_BDU = 8,
  parameter int unsigned B       = 16,
  parameter int unsigned BW      = $clog2(B)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [B-1:0]         query_x,
  input  logic [B-1:0]         query_y,
  input  logic [B-1:0]         query_z,
  input  logic [15:0]          ref_count,
  input  logic                 ref_valid,
  output logic                 ref_ready,
  input  logic [NUM_BDU*B-1:0] ref_x,
  input  logic [NUM_BDU*B-1:0] ref_y,
  input  logic [NUM_BDU*B-1:0] ref_z,
  input  logic [NUM_BDU-1:0]   ref_mask,
  input  logic                 shift,
`ifdef BDU_STREAM_STALL_EN
  input  logic                 stall,
`endif
  output logic [NUM_BDU-1:0]   bdu_valid,
  output logic [NUM_BDU-1:0]   bdu_q_bit,
  output logic [NUM_BDU-1:0]   bdu_r_bit,
  output logic [1:0]           bdu_code,
  output logic [BW-1:0]        bdu_b,
  output logic                 batch_done,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {StIdle, StFetch, StStream, StFinish} state_e;

  state_e               state_q, state_d;
  logic [B-1:0]         qx_q, qy_q, qz_q, qx_d, qy_d, qz_d;
  logic [NUM_BDU*B-1:0] rx_q, ry_q, rz_q, rx_d, ry_d, rz_d;
  logic [NUM_BDU-1:0]   mask_q, mask_d;
  logic [15:0]          remaining_q, remaining_d;
  logic [BW-1:0]        b_q, b_d;
  logic [1:0]           code_q, code_d;
  logic                 shown_q, shown_d;
  logic                 ready_q, ready_d;
  logic [NUM_BDU-1:0]   valid_q, valid_d, qbit_q, qbit_d, rbit_q, rbit_d;
  logic [1:0]           ocode_q, ocode_d;
  logic [BW-1:0]        ob_q, ob_d;
  logic                 bdone_q, bdone_d, busy_q, busy_d, done_q, done_d;

  logic                 stall_in;
  logic                 disp;
  logic [BW-1:0]        tgt_b;
  logic [1:0]           tgt_code;
  logic [NUM_BDU*B-1:0] sx, sy, sz;
  logic [NUM_BDU-1:0]   smask;

`ifdef BDU_STREAM_STALL_EN
  assign stall_in = stall;
`else
  assign stall_in = 1'b0;
`endif

  function automatic logic axis_bit(input logic [B-1:0] x, input logic [B-1:0] y,
                                    input logic [B-1:0] z, input logic [1:0] c,
                                    input logic [BW-1:0] idx);
    case (c)
      2'd0:    return x[idx];
      2'd1:    return y[idx];
      default: return z[idx];
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    qx_d        = qx_q;
    qy_d        = qy_q;
    qz_d        = qz_q;
    rx_d        = rx_q;
    ry_d        = ry_q;
    rz_d        = rz_q;
    mask_d      = mask_q;
    remaining_d = remaining_q;
    b_d         = b_q;
    code_d      = code_q;
    shown_d     = 1'b0;
    ready_d     = 1'b0;
    valid_d     = '0;
    qbit_d      = '0;
    rbit_d      = '0;
    ocode_d     = ocode_q;
    ob_d        = ob_q;
    bdone_d     = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    disp        = 1'b0;
    tgt_b       = b_q;
    tgt_code    = code_q;
    sx          = rx_q;
    sy          = ry_q;
    sz          = rz_q;
    smask       = mask_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          qx_d        = query_x;
          qy_d        = query_y;
          qz_d        = query_z;
          remaining_d = ref_count;
          busy_d      = 1'b1;
          if (ref_count == 16'd0) begin
            state_d = StFinish;
          end else begin
            state_d = StFetch;
            ready_d = 1'b1;
          end
        end
      end
      StFetch: begin
        ready_d = 1'b1;
        if (ref_valid && ready_q) begin
          // First beat comes straight from the inputs so it lands the cycle after transfer
          ready_d  = 1'b0;
          rx_d     = ref_x;
          ry_d     = ref_y;
          rz_d     = ref_z;
          mask_d   = ref_mask;
          sx       = ref_x;
          sy       = ref_y;
          sz       = ref_z;
          smask    = ref_mask;
          tgt_b    = BW'(B - 1);
          tgt_code = 2'd0;
          disp     = 1'b1;
          state_d  = StStream;
        end
      end
      StStream: begin
        if (shift || (shown_q && b_q == '0 && code_q == 2'd2)) begin
          bdone_d     = 1'b1;
          remaining_d = (remaining_q > 16'(NUM_BDU)) ? remaining_q - 16'(NUM_BDU) : 16'd0;
          if (remaining_d != 16'd0) begin
            state_d = StFetch;
            ready_d = 1'b1;
          end else begin
            state_d = StFinish;
          end
        end else begin
          // b_q/code_q name the beat on the outputs, or the pending beat after a stall
          if (shown_q) begin
            if (code_q == 2'd2) begin
              tgt_code = 2'd0;
              tgt_b    = b_q - BW'(1);
            end else begin
              tgt_code = code_q + 2'd1;
            end
          end
          b_d    = tgt_b;
          code_d = tgt_code;
          disp   = !stall_in;
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (disp) begin
      shown_d = 1'b1;
      b_d     = tgt_b;
      code_d  = tgt_code;
      ob_d    = tgt_b;
      ocode_d = tgt_code;
      valid_d = smask;
      qbit_d  = {NUM_BDU{axis_bit(qx_d, qy_d, qz_d, tgt_code, tgt_b)}};
      for (int i = 0; i < NUM_BDU; i++) begin
        rbit_d[i] = axis_bit(sx[i*B +: B], sy[i*B +: B], sz[i*B +: B], tgt_code, tgt_b);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      qx_q        <= '0;
      qy_q        <= '0;
      qz_q        <= '0;
      rx_q        <= '0;
      ry_q        <= '0;
      rz_q        <= '0;
      mask_q      <= '0;
      remaining_q <= '0;
      b_q         <= '0;
      code_q      <= '0;
      shown_q     <= 1'b0;
      ready_q     <= 1'b0;
      valid_q     <= '0;
      qbit_q      <= '0;
      rbit_q      <= '0;
      ocode_q     <= '0;
      ob_q        <= '0;
      bdone_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      qx_q        <= qx_d;
      qy_q        <= qy_d;
      qz_q        <= qz_d;
      rx_q        <= rx_d;
      ry_q        <= ry_d;
      rz_q        <= rz_d;
      mask_q      <= mask_d;
      remaining_q <= remaining_d;
      b_q         <= b_d;
      code_q      <= code_d;
      shown_q     <= shown_d;
      ready_q     <= ready_d;
      valid_q     <= valid_d;
      qbit_q      <= qbit_d;
      rbit_q      <= rbit_d;
      ocode_q     <= ocode_d;
      ob_q        <= ob_d;
      bdone_q     <= bdone_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ref_ready  = ready_q;
  assign bdu_valid  = valid_q;
  assign bdu_q_bit  = qbit_q;
  assign bdu_r_bit  = rbit_q;
  assign bdu_code   = ocode_q;
  assign bdu_b      = ob_q;
  assign batch_done = bdone_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_bdu_bit_streamer.sv
// Scoreboard bench for bdu_bit_streamer (NUM_BDU=2, B=4): expected beats are queued as stimulus
// is issued and a negedge monitor pops and compares every presented beat.
module tb_bdu_bit_streamer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] query_x = 4'hA, query_y = 4'h3, query_z = 4'hF;
  logic [15:0] ref_count = '0;
  logic       ref_valid = 1'b0;
  logic       ref_ready;
  logic [7:0] ref_x = {4'hF, 4'h5}, ref_y = {4'h0, 4'hC}, ref_z = {4'h9, 4'h0};
  logic [1:0] ref_mask = 2'b11;
  logic       shift = 1'b0;
`ifdef BDU_STREAM_STALL_EN
  logic       stall = 1'b0;
`endif
  logic [1:0] bdu_valid, bdu_q_bit, bdu_r_bit, bdu_code, bdu_b;
  logic       batch_done, busy, done;

  always #5 clk = ~clk;

  bdu_bit_streamer #(.NUM_BDU(2), .B(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .query_x(query_x), .query_y(query_y), .query_z(query_z),
    .ref_count(ref_count), .ref_valid(ref_valid), .ref_ready(ref_ready),
    .ref_x(ref_x), .ref_y(ref_y), .ref_z(ref_z), .ref_mask(ref_mask),
    .shift(shift),
`ifdef BDU_STREAM_STALL_EN
    .stall(stall),
`endif
    .bdu_valid(bdu_valid), .bdu_q_bit(bdu_q_bit), .bdu_r_bit(bdu_r_bit),
    .bdu_code(bdu_code), .bdu_b(bdu_b), .batch_done(batch_done), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [1:0] valid;
    logic       q;
    logic [1:0] r;
    logic [1:0] code;
    logic [1:0] b;
  } beat_t;

  beat_t sb[$];
  int vectors = 0, miscompares = 0;
  int beat_cnt = 0, bd_cnt = 0, done_cnt = 0, rdy_cnt = 0, bd_at_done = 0;

  // Hand-computed: query (A,3,F); lane0 (5,C,0), lane1 (F,0,9); r = {lane1, lane0}
  logic       qtab[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [1:0] rtab[12] = '{2'b10, 2'b01, 2'b10, 2'b11, 2'b01, 2'b00,
                           2'b10, 2'b00, 2'b00, 2'b11, 2'b00, 2'b10};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_batch(input int n, input logic [1:0] mask);
    for (int i = 0; i < n; i++) begin
      sb.push_back('{mask, qtab[i], rtab[i], 2'(i % 3), 2'(3 - i / 3)});
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (batch_done) bd_cnt++;
      if (done) begin
        done_cnt++;
        bd_at_done = bd_cnt;
      end
      if (ref_ready) rdy_cnt++;
      if (bdu_valid != 2'b00) begin
        beat_t e;
        beat_cnt++;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL beat: unexpected beat valid=%b code=%0d b=%0d", bdu_valid, bdu_code,
                   bdu_b);
        end else begin
          e = sb.pop_front();
          if (bdu_valid !== e.valid || bdu_q_bit !== {2{e.q}} ||
              (bdu_r_bit & bdu_valid) !== (e.r & e.valid) || bdu_code !== e.code ||
              bdu_b !== e.b) begin
            miscompares++;
            $display("FAIL beat: got v=%b q=%b r=%b c=%0d b=%0d expected v=%b q=%b r=%b c=%0d b=%0d",
                     bdu_valid, bdu_q_bit, bdu_r_bit & bdu_valid, bdu_code, bdu_b,
                     e.valid, {2{e.q}}, e.r & e.valid, e.code, e.b);
          end
        end
      end
    end
  end

  function automatic int cnt(input int which);
    case (which)
      0:       return beat_cnt;
      1:       return bd_cnt;
      default: return done_cnt;
    endcase
  endfunction

  task automatic wait_for(input string name, input int which, input int target);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (cnt(which) >= target) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL %s: timeout, got %0d expected %0d", name, cnt(which), target);
  endtask

  task automatic do_start(input logic [15:0] rc);
    @(negedge clk);
    ref_count = rc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input logic [1:0] mask);
    @(negedge clk);
    ref_mask = mask;
    ref_valid = 1'b1;
    for (int i = 0; i < 400 && !ref_ready; i++) @(negedge clk);
    if (!ref_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL feed: ref_ready got 0 expected 1");
    end
    @(posedge clk);
    #1 ref_valid = 1'b0;
  endtask

  initial begin
    int b0, d0, r0;
    #3;
    check("reset_outputs", {bdu_valid, bdu_q_bit, bdu_r_bit, bdu_code, bdu_b, batch_done, busy,
                            done, ref_ready}, 0);
    @(negedge clk) rst = 1'b1;

    // 1: full batch, no shift
    b0 = beat_cnt; d0 = bd_cnt;
    do_start(16'd2);
    check("t1_busy", busy, 1);
    push_batch(12, 2'b11);
    feed(2'b11);
    wait_for("t1_batch_done", 1, d0 + 1);
    check("t1_beats", beat_cnt - b0, 12);
    check("t1_valid_after", bdu_valid, 0);
    check("t1_done_early", done, 0);
    @(negedge clk); #1;
    check("t1_done", done, 1);
    check("t1_busy_clear", busy, 0);

    // 2: shift during 5th beat
    b0 = beat_cnt; d0 = bd_cnt; r0 = done_cnt;
    do_start(16'd2);
    push_batch(5, 2'b11);
    feed(2'b11);
    wait_for("t2_beats", 0, b0 + 5);
    shift = 1'b1;
    @(posedge clk); #1 shift = 1'b0;
    @(negedge clk); #1;
    check("t2_valid_off", bdu_valid, 0);
    check("t2_batch_done", batch_done, 1);
    repeat (5) @(negedge clk);
    #1;
    check("t2_bd_count", bd_cnt - d0, 1);
    check("t2_done_count", done_cnt - r0, 1);
    check("t2_beats", beat_cnt - b0, 5);
    check("t2_sb_empty", sb.size(), 0);

    // 3: ref_count=5 -> three batches, last one lane0 only
    b0 = beat_cnt; d0 = bd_cnt; r0 = done_cnt;
    do_start(16'd5);
    push_batch(12, 2'b11); feed(2'b11);
    push_batch(12, 2'b11); feed(2'b11);
    push_batch(12, 2'b01); feed(2'b01);
    wait_for("t3_done", 2, r0 + 1);
    check("t3_bd_before_done", bd_at_done - d0, 3);
    repeat (5) @(negedge clk);
    #1;
    check("t3_bd_count", bd_cnt - d0, 3);
    check("t3_beats", beat_cnt - b0, 36);
    check("t3_sb_empty", sb.size(), 0);

    // 4: ref_count=0, start held while busy is ignored
    r0 = rdy_cnt; d0 = done_cnt;
    @(negedge clk);
    ref_count = 16'd0;
    start = 1'b1;
    @(negedge clk); #1;
    check("t4_done_c1", done, 0);
    check("t4_busy_c1", busy, 1);
    ref_count = 16'd2;
    @(negedge clk); #1;
    start = 1'b0;
    check("t4_done_c2", done, 1);
    repeat (4) @(negedge clk);
    #1;
    check("t4_busy_idle", busy, 0);
    check("t4_done_count", done_cnt - d0, 1);
    check("t4_ready_never", rdy_cnt - r0, 0);

    // 5: async reset mid-stream, then a clean restart
    do_start(16'd2);
    push_batch(12, 2'b11);
    feed(2'b11);
    b0 = beat_cnt;
    wait_for("t5_beats", 0, b0 + 3);
    #2 rst = 1'b0;
    #1;
    check("t5_reset_outputs", {bdu_valid, bdu_q_bit, bdu_r_bit, bdu_code, bdu_b, batch_done, busy,
                               done, ref_ready}, 0);
    sb.delete();
    @(negedge clk) rst = 1'b1;
    b0 = beat_cnt; r0 = done_cnt;
    do_start(16'd2);
    push_batch(12, 2'b11);
    feed(2'b11);
    wait_for("t5_done", 2, r0 + 1);
    check("t5_beats", beat_cnt - b0, 12);
    check("t5_sb_empty", sb.size(), 0);

    // 6: shift on the final beat gives a single batch end
    b0 = beat_cnt; d0 = bd_cnt; r0 = done_cnt;
    do_start(16'd2);
    push_batch(12, 2'b11);
    feed(2'b11);
    wait_for("t6_beats", 0, b0 + 12);
    shift = 1'b1;
    @(posedge clk); #1 shift = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("t6_bd_count", bd_cnt - d0, 1);
    check("t6_done_count", done_cnt - r0, 1);
    check("t6_sb_empty", sb.size(), 0);

`ifdef BDU_STREAM_STALL_EN
    // Stall for three cycles before beat 4: beat 4 follows the stall, 12 beats total
    b0 = beat_cnt; d0 = bd_cnt;
    do_start(16'd2);
    push_batch(12, 2'b11);
    feed(2'b11);
    wait_for("st_beats", 0, b0 + 3);
    stall = 1'b1;
    repeat (3) @(posedge clk);
    #1 stall = 1'b0;
    check("st_valid_held", bdu_valid, 0);
    wait_for("st_batch_done", 1, d0 + 1);
    check("st_beats", beat_cnt - b0, 12);
    check("st_sb_empty", sb.size(), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
